e3_arb2: RTL and testbench

- Two-requester round-robin arbiter with hold and timeout.
- Sequences access to a shared resource, enabled by a master enable.
- Grant-valid (busy) follows the lab's vote function, en AND (req0 OR req1), with registered timing, fairness and hold.
- Sits between two request sources and the shared datapath it gates.

---
 rtl/e3_arb2.sv | 102 ++++++++++
 tb/tb_e3_arb2.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/e3_arb2.sv
// rtl/e3_arb2.sv - two-requester round-robin arbiter with hold limit and timeout pulse
module e3_arb2 #(
    parameter int CW       = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       done,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       to_pulse,
    output logic       last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    // Counter value on the final cycle a grant may be held.
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    state_t        nxt_state;
    logic [CW-1:0] nxt_cnt;
    logic          nxt_pulse;
    logic          nxt_last;

    logic          own_req;
    logic          oth_req;
    logic          timeout;
    logic          release_now;
    logic          pick;

    // Decide the next owner, hold count and timeout pulse from the current grant and inputs.
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_pulse   = 1'b0;
        nxt_last    = last;
        own_req     = (state == G1) ? req[1] : req[0];
        oth_req     = (state == G1) ? req[0] : req[1];
        timeout     = (cnt == CNT_LAST);
        release_now = !en || !own_req || done || timeout;
        // On a tie the requester that was not served most recently wins.
        pick        = (req == 2'b11) ? ~last : req[1];

        case (state)
            IDLE: begin
                if (en && (req != 2'b00)) begin
                    nxt_state = pick ? G1 : G0;
                    nxt_last  = pick;
                    nxt_cnt   = '0;
                end
            end
            G0, G1: begin
                if (release_now) begin
                    // Only a pure timeout (no earlier release reason) raises the pulse.
                    nxt_pulse = en && own_req && !done && timeout;
                    nxt_cnt   = '0;
                    if (en && oth_req) begin
                        nxt_state = (state == G1) ? G0 : G1;
                        nxt_last  = (state == G0);
                    end else begin
                        nxt_state = IDLE;
                    end
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // State register with grant outputs decoded from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt      <= 2'b00;
            busy     <= 1'b0;
            to_pulse <= 1'b0;
            last     <= 1'b1;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            gnt      <= {nxt_state == G1, nxt_state == G0};
            busy     <= (nxt_state != IDLE);
            to_pulse <= nxt_pulse;
            last     <= nxt_last;
        end
    end

endmodule

// File: tb/tb_e3_arb2.sv
// tb/tb_e3_arb2.sv - vector, sequence and randomized model checks for e3_arb2
module tb_e3_arb2;

    logic       clk = 1'b0;
    logic       rst, en, done;
    logic [1:0] req;
    logic [1:0] gnt_a, gnt_b;
    logic       busy_a, busy_b, pulse_a, pulse_b, last_a, last_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    e3_arb2 #(.CW(4), .HOLD_MAX(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
        .gnt(gnt_a), .busy(busy_a), .to_pulse(pulse_a), .last(last_a)
    );

    e3_arb2 #(.CW(4), .HOLD_MAX(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
        .gnt(gnt_b), .busy(busy_b), .to_pulse(pulse_b), .last(last_b)
    );

    // Reference model: owner (-1 idle), cycles the grant has been visible, last grantee.
    int hm[2]      = '{8, 1};
    int m_own[2]   = '{-1, -1};
    int m_len[2]   = '{0, 0};
    bit m_last[2]  = '{1'b1, 1'b1};
    bit m_pulse[2] = '{1'b0, 1'b0};

    task automatic model_step(input int k);
        int o;
        bit to, ended;
        if (rst) begin
            m_own[k] = -1; m_len[k] = 0; m_last[k] = 1'b1; m_pulse[k] = 1'b0;
        end else if (m_own[k] < 0) begin
            m_pulse[k] = 1'b0;
            if (en && req != 2'b00) begin
                if (req == 2'b11) o = m_last[k] ? 0 : 1;
                else              o = req[1] ? 1 : 0;
                m_own[k] = o; m_last[k] = o[0]; m_len[k] = 1;
            end
        end else begin
            o          = m_own[k];
            to         = (m_len[k] == hm[k]);
            ended      = !en || !req[o] || done || to;
            m_pulse[k] = en && req[o] && !done && to;
            if (ended) begin
                if (en && req[1-o]) begin
                    m_own[k] = 1 - o; m_last[k] = m_own[k][0]; m_len[k] = 1;
                end else begin
                    m_own[k] = -1; m_len[k] = 0;
                end
            end else begin
                m_len[k] = m_len[k] + 1;
            end
        end
    endtask

    function automatic logic [1:0] m_gnt(input int k);
        return (m_own[k] < 0) ? 2'b00 : ((m_own[k] == 0) ? 2'b01 : 2'b10);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] q, input logic d);
        rst = r; en = e; req = q; done = d;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [1:0] q;
        logic       d;
        logic [1:0] g;
        logic       p;
        logic       l;
    } vec_t;

    vec_t vt[$];

    initial begin
        rst = 1'b1; en = 1'b0; req = 2'b00; done = 1'b0;

        // Reset then idle
        vt.push_back('{1, 0, 2'b00, 0, 2'b00, 0, 1});
        vt.push_back('{1, 0, 2'b00, 0, 2'b00, 0, 1});
        for (int i = 0; i < 5; i++) vt.push_back('{0, 1, 2'b00, 0, 2'b00, 0, 1});
        // Single request released by done
        vt.push_back('{0, 1, 2'b01, 0, 2'b01, 0, 0});
        vt.push_back('{0, 1, 2'b01, 0, 2'b01, 0, 0});
        vt.push_back('{0, 1, 2'b01, 0, 2'b01, 0, 0});
        vt.push_back('{0, 1, 2'b01, 1, 2'b00, 0, 0});
        vt.push_back('{0, 1, 2'b00, 0, 2'b00, 0, 0});
        // Tie from reset: alternating with direct handoff
        vt.push_back('{1, 1, 2'b00, 0, 2'b00, 0, 1});
        vt.push_back('{0, 1, 2'b11, 0, 2'b01, 0, 0});
        vt.push_back('{0, 1, 2'b11, 0, 2'b01, 0, 0});
        vt.push_back('{0, 1, 2'b11, 1, 2'b10, 0, 1});
        vt.push_back('{0, 1, 2'b11, 0, 2'b10, 0, 1});
        vt.push_back('{0, 1, 2'b11, 1, 2'b01, 0, 0});
        vt.push_back('{0, 1, 2'b11, 0, 2'b01, 0, 0});
        vt.push_back('{0, 1, 2'b11, 1, 2'b10, 0, 1});
        vt.push_back('{0, 1, 2'b11, 0, 2'b10, 0, 1});
        // Enable drop mid-G0
        vt.push_back('{1, 1, 2'b00, 0, 2'b00, 0, 1});
        vt.push_back('{0, 1, 2'b01, 0, 2'b01, 0, 0});
        vt.push_back('{0, 0, 2'b01, 0, 2'b00, 0, 0});
        vt.push_back('{0, 0, 2'b01, 0, 2'b00, 0, 0});
        // Requester drops its line while a competitor waits
        vt.push_back('{0, 1, 2'b11, 0, 2'b10, 0, 1});
        vt.push_back('{0, 1, 2'b01, 0, 2'b01, 0, 0});

        foreach (vt[i]) begin
            step(vt[i].r, vt[i].e, vt[i].q, vt[i].d);
            chk($sformatf("vec%0d_gnt", i), gnt_a, vt[i].g);
            chk($sformatf("vec%0d_pulse", i), pulse_a, vt[i].p);
            chk($sformatf("vec%0d_last", i), last_a, vt[i].l);
            chk($sformatf("vec%0d_busy", i), busy_a, (vt[i].g != 2'b00));
        end

        // Timeout: req=10 held, grant lasts exactly 8 cycles, pulse, then regrant
        step(1, 1, 2'b00, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b10, 0);
            chk($sformatf("to_hold%0d", i), gnt_a, 2'b10);
        end
        step(0, 1, 2'b10, 0);
        chk("to_gnt_idle", gnt_a, 2'b00);
        chk("to_pulse_hi", pulse_a, 1);
        step(0, 1, 2'b10, 0);
        chk("to_regrant", gnt_a, 2'b10);
        chk("to_pulse_lo", pulse_a, 0);

        // done on the edge where the counter reaches 7 wins over timeout
        step(1, 1, 2'b00, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 2'b01, 0);
        chk("col_before", gnt_a, 2'b01);
        step(0, 1, 2'b01, 1);
        chk("col_gnt", gnt_a, 2'b00);
        chk("col_pulse", pulse_a, 0);

        // Reset mid-grant with counter at 5
        step(1, 1, 2'b00, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 2'b01, 0);
        step(1, 1, 2'b11, 0);
        chk("rmid_gnt", gnt_a, 2'b00);
        chk("rmid_last", last_a, 1);
        chk("rmid_pulse", pulse_a, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b11, 0);
            chk($sformatf("rmid_hold%0d", i), gnt_a, 2'b01);
        end
        step(0, 1, 2'b11, 0);
        chk("rmid_handoff", gnt_a, 2'b10);
        chk("rmid_to_pulse", pulse_a, 1);

        // HOLD_MAX=1 instance: single-cycle grants with pulses
        step(1, 1, 2'b00, 0);
        step(0, 1, 2'b01, 0);
        chk("h1_gnt", gnt_b, 2'b01);
        step(0, 1, 2'b01, 0);
        chk("h1_gnt_idle", gnt_b, 2'b00);
        chk("h1_pulse", pulse_b, 1);

        // Randomized run against the reference model on both instances
        step(1, 0, 2'b00, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                 2'($urandom), ($urandom_range(0, 5) == 0));
            chk("rnd_gnt_a", gnt_a, m_gnt(0));
            chk("rnd_pulse_a", pulse_a, m_pulse[0]);
            chk("rnd_last_a", last_a, m_last[0]);
            chk("rnd_busy_a", busy_a, (m_own[0] >= 0));
            chk("rnd_gnt_b", gnt_b, m_gnt(1));
            chk("rnd_pulse_b", pulse_b, m_pulse[1]);
            chk("rnd_last_b", last_b, m_last[1]);
            chk("rnd_busy_b", busy_b, (m_own[1] >= 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
